// File: rtl/mmr_axi4lite_bridge_if.sv
// Register-bank link: master pulses store/store_idx/store_data, bank presents data[].
// The bank is expected to update data[store_idx] on the clock edge that ends a store cycle.
interface mmr_readwrite_interface #(
  parameter int NREGS = 16
) ();
  localparam int INDEX_WIDTH = $clog2(NREGS);

  logic                   store;
  logic [INDEX_WIDTH-1:0] store_idx;
  logic [31:0]            store_data;
  logic [31:0]            data [NREGS];

  modport master (output store, output store_idx, output store_data, input data);
  modport slave  (input store, input store_idx, input store_data, output data);
endinterface

// File: rtl/mmr_axi4lite_bridge.sv
// AXI4-Lite slave mastering an mmr_readwrite_interface: writes become one-cycle store pulses
// with byte-strobe merging, reads sample data[]; write and read channels run independently.
module mmr_axi4lite_bridge #(
  parameter int NREGS      = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  mmr_readwrite_interface.master mmr
);
  localparam int INDEX_WIDTH = $clog2(NREGS);
  localparam logic [ADDR_WIDTH-1:0] UPPER_MASK =
    ~ADDR_WIDTH'((64'd1 << (INDEX_WIDTH + 2)) - 64'd1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_STORE, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_RESP} rstate_e;

  function automatic logic [INDEX_WIDTH-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
    return a[INDEX_WIDTH+1:2];
  endfunction

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ((a & UPPER_MASK) == '0) && (32'(idx_of(a)) < 32'(NREGS));
  endfunction

  wstate_e                wstate_q, wstate_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   aw_held_q, aw_held_d;
  logic                   w_held_q, w_held_d;
  logic [INDEX_WIDTH-1:0] aw_idx_q, aw_idx_d;
  logic                   aw_ok_q, aw_ok_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;

  rstate_e                rstate_q, rstate_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [31:0]            rdata_q, rdata_d;

  logic                   store;
  logic [INDEX_WIDTH-1:0] store_idx;
  logic [31:0]            store_data;
  logic [31:0]            merged;

  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : mmr.data[aw_idx_q][8*i +: 8];
    end
  end

  always_comb begin
    wstate_d   = wstate_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    aw_ok_d    = aw_ok_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    store      = 1'b0;
    store_idx  = '0;
    store_data = '0;
    case (wstate_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          aw_held_d = 1'b1;
          aw_idx_d  = idx_of(s_axi_awaddr);
          aw_ok_d   = addr_ok(s_axi_awaddr);
        end
        if (s_axi_wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
        end
        // Readies track "not yet holding a beat", so each drops right after its capture.
        awready_d = !aw_held_d;
        wready_d  = !w_held_d;
        if (aw_held_d && w_held_d) begin
          wstate_d  = W_STORE;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end
      end
      W_STORE: begin
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        bvalid_d  = 1'b1;
        bresp_d   = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
        wstate_d  = W_RESP;
        if (aw_ok_q && (wstrb_q != 4'd0) && !reset) begin
          store      = 1'b1;
          store_idx  = aw_idx_q;
          store_data = merged;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rstate_d  = R_RESP;
          if (addr_ok(s_axi_araddr)) begin
            rdata_d = mmr.data[idx_of(s_axi_araddr)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end else begin
          arready_d = 1'b1;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      aw_ok_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_ok_q   <= aw_ok_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axi_awready  = awready_q;
  assign s_axi_wready   = wready_q;
  assign s_axi_bvalid   = bvalid_q;
  assign s_axi_bresp    = bresp_q;
  assign s_axi_arready  = arready_q;
  assign s_axi_rvalid   = rvalid_q;
  assign s_axi_rresp    = rresp_q;
  assign s_axi_rdata    = rdata_q;
  assign mmr.store      = store;
  assign mmr.store_idx  = store_idx;
  assign mmr.store_data = store_data;
endmodule

// File: tb/tb_mmr_axi4lite_bridge.sv
// Directed bench for mmr_axi4lite_bridge with a behavioural register bank on the slave side.
module tb_mmr_axi4lite_bridge;
  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [11:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  int n_checks = 0;
  int n_fail   = 0;
  int store_count = 0;

  logic [31:0] bank [16] = '{default: 32'h0};

  mmr_readwrite_interface #(.NREGS(16)) mif ();
  assign mif.data = bank;

  always @(posedge clock) begin
    if (mif.store) begin
      bank[mif.store_idx] <= mif.store_data;
      store_count <= store_count + 1;
    end
  end

  mmr_axi4lite_bridge #(.NREGS(16), .ADDR_WIDTH(12)) dut (
    .clock(clock), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .mmr(mif)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  wire [77:0] all_outs = {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_bresp,
                          s_axi_rvalid, s_axi_rresp, s_axi_rdata, mif.store, mif.store_idx,
                          mif.store_data};

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Complete a same-cycle AW+W write with bready high; bounded waits.
  task automatic do_write(input logic [11:0] addr, input logic [31:0] dat, input logic [3:0] strb);
    logic a, w, b;
    bit   aw_done = 1'b0, w_done = 1'b0, b_done = 1'b0;
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    s_axi_wdata = dat; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      a = s_axi_awready; w = s_axi_wready;
      tick;
      if (a && s_axi_awvalid) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
      if (w && s_axi_wvalid)  begin w_done = 1'b1;  s_axi_wvalid = 1'b0;  end
    end
    for (int i = 0; i < 20 && !b_done; i++) begin
      b = s_axi_bvalid;
      tick;
      if (b) b_done = 1'b1;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    n_checks++;
    if (!b_done) begin
      n_fail++;
      $display("FAIL do_write_timeout: addr %h write did not complete, got no B, required B", addr);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    repeat (3) tick;
    n_checks++;
    if (all_outs !== 78'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", all_outs);
    end
    reset = 1'b0;
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
      n_fail++; $display("FAIL ready_in_release_cycle: got %b required 000",
                         {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    tick;
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      n_fail++; $display("FAIL ready_after_reset: got %b required 111",
                         {s_axi_awready, s_axi_wready, s_axi_arready});
    end
  endtask

  task automatic test_full_write;
    s_axi_awaddr = 12'h008; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n_checks++;
    if ({mif.store, mif.store_idx, mif.store_data} !== {1'b1, 4'd2, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL full_write_store: got %b/%0d/%h required 1/2/deadbeef",
                         mif.store, mif.store_idx, mif.store_data);
    end
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b000) begin
      n_fail++; $display("FAIL full_write_ready_drop: got %b required 000",
                         {s_axi_awready, s_axi_wready, s_axi_bvalid});
    end
    tick;
    n_checks++;
    if ({s_axi_bvalid, s_axi_bresp, mif.store} !== 4'b1000) begin
      n_fail++; $display("FAIL full_write_bresp: got %b required 1000",
                         {s_axi_bvalid, s_axi_bresp, mif.store});
    end
    s_axi_bready = 1'b1;
    tick;
    s_axi_bready = 1'b0;
    n_checks++;
    if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b011) begin
      n_fail++; $display("FAIL full_write_b_done: got %b required 011",
                         {s_axi_bvalid, s_axi_awready, s_axi_wready});
    end
  endtask

  task automatic test_partial_strobe;
    do_write(12'h004, 32'h11223344, 4'hF);
    s_axi_awaddr = 12'h004; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hAABBCCDD; s_axi_wstrb = 4'h5; s_axi_wvalid = 1'b1;
    tick;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n_checks++;
    if ({mif.store, mif.store_idx, mif.store_data} !== {1'b1, 4'd1, 32'h11BB33DD}) begin
      n_fail++; $display("FAIL partial_strobe: got %b/%0d/%h required 1/1/11bb33dd",
                         mif.store, mif.store_idx, mif.store_data);
    end
    s_axi_bready = 1'b1;
    repeat (2) tick;
    s_axi_bready = 1'b0;
  endtask

  task automatic test_w_before_aw;
    int c0;
    c0 = store_count;
    s_axi_wdata = 32'h00000055; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick;
    s_axi_wvalid = 1'b0;
    n_checks++;
    if ({s_axi_wready, s_axi_awready} !== 2'b01) begin
      n_fail++; $display("FAIL w_first_ready: got %b required 01", {s_axi_wready, s_axi_awready});
    end
    repeat (2) tick;
    s_axi_awaddr = 12'h014; s_axi_awvalid = 1'b1;
    tick;
    s_axi_awvalid = 1'b0;
    n_checks++;
    if ({mif.store, mif.store_idx, mif.store_data} !== {1'b1, 4'd5, 32'h00000055}) begin
      n_fail++; $display("FAIL w_first_store: got %b/%0d/%h required 1/5/00000055",
                         mif.store, mif.store_idx, mif.store_data);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      n_checks++;
      if ({s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready, mif.store} !== 6'b100000) begin
        n_fail++; $display("FAIL b_stall_hold[%0d]: got %b required 100000", i,
                           {s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready, mif.store});
      end
    end
    s_axi_bready = 1'b1;
    tick;
    s_axi_bready = 1'b0;
    n_checks++;
    if (store_count !== c0 + 1) begin
      n_fail++; $display("FAIL w_first_store_count: got %0d required %0d", store_count, c0 + 1);
    end
  endtask

  task automatic test_out_of_range;
    int c0;
    do_write(12'h000, 32'hCAFEF00D, 4'hF);
    c0 = store_count;
    s_axi_awaddr = 12'h040; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h12121212; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n_checks++;
    if (mif.store !== 1'b0) begin
      n_fail++; $display("FAIL oor_write_store: got %b required 0", mif.store);
    end
    tick;
    n_checks++;
    if ({s_axi_bvalid, s_axi_bresp} !== 3'b110) begin
      n_fail++; $display("FAIL oor_write_bresp: got %b required 110", {s_axi_bvalid, s_axi_bresp});
    end
    s_axi_bready = 1'b1;
    tick;
    s_axi_bready = 1'b0;
    n_checks++;
    if (store_count !== c0) begin
      n_fail++; $display("FAIL oor_store_count: got %0d required %0d", store_count, c0);
    end
    s_axi_araddr = 12'h800; s_axi_arvalid = 1'b1;
    tick;
    s_axi_arvalid = 1'b0;
    n_checks++;
    if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b10, 32'h0}) begin
      n_fail++; $display("FAIL oor_read: got %b/%b/%h required 1/10/00000000",
                         s_axi_rvalid, s_axi_rresp, s_axi_rdata);
    end
    s_axi_rready = 1'b1;
    tick;
    s_axi_rready = 1'b0;
  endtask

  task automatic test_rw_overlap;
    do_write(12'h00C, 32'd5, 4'hF);
    s_axi_awaddr = 12'h00C; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'd7; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    tick;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_araddr = 12'h00C; s_axi_arvalid = 1'b1;
    n_checks++;
    if ({mif.store, s_axi_arready} !== 2'b11) begin
      n_fail++; $display("FAIL overlap_store_cycle: got %b required 11", {mif.store, s_axi_arready});
    end
    tick;
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b00, 32'd5}) begin
        n_fail++; $display("FAIL overlap_old_value[%0d]: got %b/%b/%h required 1/00/00000005", i,
                           s_axi_rvalid, s_axi_rresp, s_axi_rdata);
      end
      tick;
    end
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b1;
    tick;
    s_axi_rready = 1'b0;
    s_axi_arvalid = 1'b1;
    tick;
    s_axi_arvalid = 1'b0;
    n_checks++;
    if ({s_axi_rvalid, s_axi_rdata} !== {1'b1, 32'd7}) begin
      n_fail++; $display("FAIL overlap_new_value: got %b/%h required 1/00000007",
                         s_axi_rvalid, s_axi_rdata);
    end
    s_axi_rready = 1'b1;
    tick;
    s_axi_rready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int c0;
    c0 = store_count;
    s_axi_awaddr = 12'h010; s_axi_awvalid = 1'b1;
    tick;
    s_axi_awvalid = 1'b0;
    reset = 1'b1;
    tick;
    n_checks++;
    if (all_outs !== 78'h0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h required 0", all_outs);
    end
    reset = 1'b0;
    repeat (4) tick;
    n_checks++;
    if ({store_count != c0, s_axi_bvalid} !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset_dropped: stores %0d bvalid %b required %0d/0",
                         store_count, s_axi_bvalid, c0);
    end
    do_write(12'h010, 32'h12345678, 4'hF);
    s_axi_araddr = 12'h010; s_axi_arvalid = 1'b1;
    tick;
    s_axi_arvalid = 1'b0;
    n_checks++;
    if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b00, 32'h12345678}) begin
      n_fail++; $display("FAIL post_reset_write: got %b/%b/%h required 1/00/12345678",
                         s_axi_rvalid, s_axi_rresp, s_axi_rdata);
    end
    s_axi_rready = 1'b1;
    tick;
    s_axi_rready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_partial_strobe();
    test_w_before_aw();
    test_out_of_range();
    test_rw_overlap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mmr_axi4lite_bridge.md
# mmr_axi4lite_bridge

AXI4-Lite slave that acts as the master of an `mmr_readwrite_interface`. It turns host register writes into single-cycle `store` pulses and host reads into samples of the `data` array. It sits between the PS/host interconnect and each processor's memory-mapped register bank. It adds address decoding, byte-strobe merging, error responses and independent read and write channels.

## Interface
- `NREGS`, 16: number of 32-bit registers; must match the attached interface instance.
- `ADDR_WIDTH`, 12: AXI address width; must be at least `$clog2(NREGS)+2`.
- Derived: `INDEX_WIDTH = $clog2(NREGS)`.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `s_axi_awaddr` in ADDR_WIDTH; `s_axi_awvalid` in 1; `s_axi_awready` out 1.
- `s_axi_wdata` in 32; `s_axi_wstrb` in 4; `s_axi_wvalid` in 1; `s_axi_wready` out 1.
- `s_axi_bresp` out 2; `s_axi_bvalid` out 1; `s_axi_bready` in 1.
- `s_axi_araddr` in ADDR_WIDTH; `s_axi_arvalid` in 1; `s_axi_arready` out 1.
- `s_axi_rdata` out 32; `s_axi_rresp` out 2; `s_axi_rvalid` out 1; `s_axi_rready` in 1.
- `mmr` modport `mmr_readwrite_interface.master`: drives `store`, `store_idx`, `store_data`; reads `data[NREGS]`.

## Operation
- **Address decode:** index = `addr[INDEX_WIDTH+1:2]`; `addr[1:0]` ignored.
  - Valid iff all bits above `INDEX_WIDTH+1` are zero and index < NREGS.
  - Otherwise the access gets SLVERR (2'b10). Valid accesses get OKAY (2'b00).
- **Write FSM: W_IDLE → W_STORE → W_RESP → W_IDLE.**
  - W_IDLE: `awready`, `wready` asserted. AW and W beats are captured independently, in either order or in the same cycle. Each ready drops the cycle after its beat is captured.
  - Once both are held, go to W_STORE.
  - W_STORE, one cycle:
    - If valid and `wstrb != 0`: `store=1`, `store_idx` = index, `store_data` = per byte `wstrb[i] ? wdata : data[index]`. `data` is sampled in this cycle.
    - If invalid: no store, response SLVERR.
    - If `wstrb == 0`: no store, response OKAY.
  - W_RESP: `bvalid=1` with `bresp` until `bready`. Then return to W_IDLE; both readies reassert on the next cycle.
- **Read FSM: R_IDLE → R_RESP → R_IDLE.**
  - R_IDLE: `arready=1`.
  - On handshake, register `rdata` = valid ? `data[index]` : 0, and `rresp`.
  - R_RESP: `rvalid=1`, `rdata`/`rresp` held stable until `rready`, then R_IDLE.
- **Channel independence:** read and write channels are fully independent and run concurrently.
  - A read accepted in the same cycle as a W_STORE store returns the pre-store value.
  - A read accepted the cycle after returns the new value, since the register bank updates on the store edge.
- **Outstanding transactions:** at most one outstanding write and one outstanding read. No ID, burst or `prot` handling.

## Timing
- **Reset values:** all outputs 0, namely `awready`, `wready`, `arready`, `bvalid`, `bresp`, `rvalid`, `rresp`, `rdata`, `store`, `store_idx`, `store_data`. FSMs return to IDLE.
- Readies first assert in the cycle after `reset` deasserts.
- **Write latency:** with the later of the AW/W handshakes in cycle N, `store` pulses in N+1 and `bvalid` rises in N+2.
- **Read latency:** with the AR handshake in cycle N, `rvalid` rises in N+1.
- **Store pulse:** `store` is high for exactly one cycle per valid nonzero-strobe write. It is never asserted outside W_STORE.
- **Stall rule:** `bvalid`/`rvalid` with stalled ready holds all response signals and blocks new beats on that channel.
- **Reset mid-transaction:** reset drops the transaction without completing it, with no `store` and no response. `store` is forced to 0 in the reset cycle.

## Test plan
- **Full write:** AW addr 0x008 and W 0xDEADBEEF/strb 0xF in the same cycle → `store=1`, `store_idx=2`, `store_data=0xDEADBEEF` one cycle later; `bresp=OKAY` the cycle after.
- **Partial strobe:** `data[1]=0x11223344`; write 0xAABBCCDD/strb 0x5 to 0x004 → `store_data=0x11BB33DD`.
- **W before AW:** W presented 3 cycles ahead of AW, `bready` held low 4 cycles → one `store` only; `bvalid` held with stable `bresp`; no second write accepted until B completes.
- **Out of range:** NREGS=16, write to 0x040 → no `store`, `bresp=SLVERR`. Read 0x800 → `rdata=0`, `rresp=SLVERR`.
- **Read/write overlap:** `data[3]=5`; write 7 to idx 3 with AR to 0x00C in the store cycle → `rdata=5`. A repeat read returns 7. `rready` low 2 cycles holds `rdata` stable.
- **Reset mid-operation:** assert `reset` between AW capture and W → no `store`, no `bvalid`, all outputs 0. A subsequent normal write completes correctly.
